// File: rtl/hash_if.sv
`default_nettype none
// ============================================================================
// Module   : hash_if
// Brief    : Block-strobe / key-word / result bundle for the lookup3 engine.
// Revision : 1.0
// ============================================================================
interface hash_if;
  logic        enable;
  logic [7:0]  key_length;
  logic [31:0] k0;
  logic [31:0] k1;
  logic [31:0] k2;
  logic [31:0] hashkey;
  logic        complete;

  modport master (
    output enable, key_length, k0, k1, k2,
    input  hashkey, complete
  );

  modport slave (
    input  enable, key_length, k0, k1, k2,
    output hashkey, complete
  );
endinterface
`default_nettype wire

// File: rtl/hash.sv
`default_nettype none
// ============================================================================
// Module   : hash
// Brief    : Streaming Jenkins lookup3 (hashlittle) engine, one 12-byte block
//            per enabled cycle, registered 32-bit result with complete pulse.
// Revision : 1.0
// ============================================================================
module hash #(
  parameter logic [31:0] INITVAL = 32'h0
) (
  input  wire logic CLK,
  input  wire logic RST,
  hash_if.slave     bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ABSORB = 1'b1
  } state_t;

  localparam logic [31:0] c_golden      = 32'hdeadbeef;
  localparam logic [7:0]  c_block_bytes = 8'd12;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_a, r_b, r_c;
  logic [31:0] w_a_nxt, w_b_nxt, w_c_nxt;
  logic [7:0]  r_remaining;
  logic [7:0]  w_remaining_nxt;
  logic [31:0] r_hashkey;
  logic [31:0] w_hashkey_nxt;
  logic        r_complete;
  logic        w_complete_nxt;

  logic        w_first;
  logic [31:0] w_seed;
  logic [31:0] w_a0, w_b0, w_c0;
  logic [7:0]  w_rem0;
  logic [95:0] w_mask;
  logic [95:0] w_words;
  logic [95:0] w_sum;
  logic [95:0] w_mixed;
  logic [31:0] w_final_c;

  function automatic logic [31:0] rot(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // State vectors are packed {a, b, c}.
  function automatic logic [95:0] mix(input logic [95:0] s);
    logic [31:0] a, b, c;
    {a, b, c} = s;
    a -= c; a ^= rot(c, 4);  c += b;
    b -= a; b ^= rot(a, 6);  a += c;
    c -= b; c ^= rot(b, 8);  b += a;
    a -= c; a ^= rot(c, 16); c += b;
    b -= a; b ^= rot(a, 19); a += c;
    c -= b; c ^= rot(b, 4);  b += a;
    return {a, b, c};
  endfunction

  function automatic logic [31:0] fin(input logic [95:0] s);
    logic [31:0] a, b, c;
    {a, b, c} = s;
    c ^= b; c -= rot(b, 14);
    a ^= c; a -= rot(c, 11);
    b ^= a; b -= rot(a, 25);
    c ^= b; c -= rot(b, 16);
    a ^= c; a -= rot(c, 4);
    b ^= a; b -= rot(a, 14);
    c ^= b; c -= rot(b, 24);
    return c;
  endfunction

  // A new message starts from the seeded state regardless of what a/b/c hold.
  assign w_first = (r_state == IDLE);
  assign w_seed  = c_golden + {24'b0, bus.key_length} + INITVAL;
  assign w_a0    = w_first ? w_seed : r_a;
  assign w_b0    = w_first ? w_seed : r_b;
  assign w_c0    = w_first ? w_seed : r_c;
  assign w_rem0  = w_first ? bus.key_length : r_remaining;

  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_mask
      localparam logic [7:0] c_idx = 8'(gi);
      assign w_mask[gi*8 +: 8] = (w_rem0 > c_idx) ? 8'hff : 8'h00;
    end
  endgenerate

  assign w_words   = {bus.k2, bus.k1, bus.k0} & w_mask;
  assign w_sum     = {w_a0 + w_words[31:0], w_b0 + w_words[63:32], w_c0 + w_words[95:64]};
  assign w_mixed   = mix(w_sum);
  assign w_final_c = fin(w_sum);

  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_c_nxt         = r_c;
    w_remaining_nxt = r_remaining;
    w_hashkey_nxt   = r_hashkey;
    w_complete_nxt  = 1'b0;
    if (bus.enable) begin
      if (w_rem0 == 8'd0) begin
        // Empty key: the seed itself is the hash, no final mix.
        w_hashkey_nxt  = w_c0;
        w_complete_nxt = 1'b1;
        w_state_nxt    = IDLE;
      end else if (w_rem0 <= c_block_bytes) begin
        w_hashkey_nxt   = w_final_c;
        w_complete_nxt  = 1'b1;
        w_remaining_nxt = 8'd0;
        w_state_nxt     = IDLE;
      end else begin
        {w_a_nxt, w_b_nxt, w_c_nxt} = w_mixed;
        w_remaining_nxt = w_rem0 - c_block_bytes;
        w_state_nxt     = ABSORB;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_c         <= 32'h0;
      r_remaining <= 8'h0;
      r_hashkey   <= 32'h0;
      r_complete  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_c         <= w_c_nxt;
      r_remaining <= w_remaining_nxt;
      r_hashkey   <= w_hashkey_nxt;
      r_complete  <= w_complete_nxt;
    end
  end

  assign bus.hashkey  = r_hashkey;
  assign bus.complete = r_complete;

endmodule
`default_nettype wire

// File: tb/tb_hash.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash
// Brief    : Self-checking bench for hash against a byte-oriented lookup3 model.
// Revision : 1.0
// ============================================================================
module tb_hash;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  hash_if if0 ();
  hash_if if1 ();

  hash #(.INITVAL(32'h0)) dut0 (.CLK(CLK), .RST(RST), .bus(if0));
  hash #(.INITVAL(32'h1)) dut1 (.CLK(CLK), .RST(RST), .bus(if1));

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [7:0]  msg [0:263];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int off);
    return {msg[off+3], msg[off+2], msg[off+1], msg[off]};
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [95:0] ref_mix(input logic [95:0] s);
    logic [31:0] a, b, c;
    {a, b, c} = s;
    a = a - c; a = a ^ rl(c, 4);  c = c + b;
    b = b - a; b = b ^ rl(a, 6);  a = a + c;
    c = c - b; c = c ^ rl(b, 8);  b = b + a;
    a = a - c; a = a ^ rl(c, 16); c = c + b;
    b = b - a; b = b ^ rl(a, 19); a = a + c;
    c = c - b; c = c ^ rl(b, 4);  b = b + a;
    return {a, b, c};
  endfunction

  function automatic logic [31:0] ref_final(input logic [31:0] a0, b0, c0);
    logic [31:0] a, b, c;
    a = a0; b = b0; c = c0;
    c = (c ^ b) - rl(b, 14);
    a = (a ^ c) - rl(c, 11);
    b = (b ^ a) - rl(a, 25);
    c = (c ^ b) - rl(b, 16);
    a = (a ^ c) - rl(c, 4);
    b = (b ^ a) - rl(a, 14);
    c = (c ^ b) - rl(b, 24);
    return c;
  endfunction

  // Mirrors C hashlittle's byte-wise path over msg[0..len-1].
  function automatic logic [31:0] ref_hash(input int len, input logic [31:0] iv);
    logic [31:0] a, b, c;
    logic [31:0] t [3];
    int n, off;
    a = 32'hdeadbeef + 32'(len) + iv; b = a; c = a;
    if (len == 0) return c;
    n = len; off = 0;
    while (n > 12) begin
      a = a + word(off); b = b + word(off + 4); c = c + word(off + 8);
      {a, b, c} = ref_mix({a, b, c});
      n -= 12; off += 12;
    end
    for (int i = 0; i < 3; i++) t[i] = 32'h0;
    for (int i = 0; i < n; i++) t[i/4] = t[i/4] + (32'(msg[off+i]) << (8 * (i % 4)));
    a = a + t[0]; b = b + t[1]; c = c + t[2];
    return ref_final(a, b, c);
  endfunction

  // Key is s repeated up to len bytes; the rest is random junk that must be masked.
  task automatic fill(input string s, input int len);
    for (int i = 0; i < 264; i++)
      msg[i] = (i < len) ? s[i % s.len()] : 8'($urandom);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 264; i++) msg[i] = 8'($urandom);
  endtask

  task automatic drive(input logic en, input logic [7:0] kl, input int off);
    if0.enable = en;          if1.enable = en;
    if0.key_length = kl;      if1.key_length = kl;
    if0.k0 = word(off);       if1.k0 = word(off);
    if0.k1 = word(off + 4);   if1.k1 = word(off + 4);
    if0.k2 = word(off + 8);   if1.k2 = word(off + 8);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int len, input int stall_blk, input int stall_n, input bit rnd);
    int nblk;
    int gap;
    logic [31:0] e0, e1;
    nblk = (len == 0) ? 1 : (len + 11) / 12;
    e0 = ref_hash(len, 32'h0);
    e1 = ref_hash(len, 32'h1);
    for (int bi = 0; bi < nblk; bi++) begin
      drive(1'b1, (bi == 0) ? 8'(len) : 8'($urandom), bi * 12);
      tick();
      drive(1'b0, 8'($urandom), 0);
      if (bi == nblk - 1) begin
        check("complete_last", {31'b0, if0.complete}, 32'd1);
        check("hash_iv0", if0.hashkey, e0);
        check("hash_iv1", if1.hashkey, e1);
      end else begin
        check("complete_mid", {31'b0, if0.complete}, 32'd0);
        gap = (bi == stall_blk) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
        repeat (gap) begin
          tick();
          check("complete_stall", {31'b0, if0.complete}, 32'd0);
        end
      end
    end
  endtask

  initial begin
    int edge_lens [7] = '{1, 11, 12, 13, 24, 25, 255};

    fill_rand();
    drive(1'b0, 8'h0, 0);
    RST = 1'b0;
    repeat (2) tick();
    check("rst_hash", if0.hashkey, 32'h0);
    check("rst_complete", {31'b0, if0.complete}, 32'd0);
    RST = 1'b1;
    tick();

    // Empty key
    fill("x", 0);
    send(0, -1, 0, 1'b0);
    check("zero_len_const", if0.hashkey, 32'hdeadbeef);
    tick();
    check("complete_drop", {31'b0, if0.complete}, 32'd0);
    check("hash_hold", if0.hashkey, 32'hdeadbeef);

    // Published lookup3 vectors, straight and with a stall mid-message
    fill("Four score and seven years ago", 30);
    send(30, -1, 0, 1'b0);
    check("four_score_iv0", if0.hashkey, 32'h17770551);
    check("four_score_iv1", if1.hashkey, 32'hcd628161);
    send(30, 1, 3, 1'b0);
    check("four_score_stall", if0.hashkey, 32'h17770551);

    // Back-to-back keys
    fill("abc", 3);                    send(3, -1, 0, 1'b0);
    fill("abcdefghijkl", 12);          send(12, -1, 0, 1'b0);
    fill("abcdefghijklmno", 15);       send(15, -1, 0, 1'b0);
    fill("abcdefghijklmnopqrst", 100); send(100, -1, 0, 1'b0);
    fill("abcdefghijklmnopqrst", 200); send(200, -1, 0, 1'b0);
    fill("abcdefghijklmnopqrst", 250); send(250, -1, 0, 1'b0);
    tick();
    check("idle_no_complete", {31'b0, if0.complete}, 32'd0);

    // Abort mid-message with an asynchronous reset
    fill("abcdefghijklmnopqrst", 100);
    for (int bi = 0; bi < 4; bi++) begin
      drive(1'b1, (bi == 0) ? 8'd100 : 8'($urandom), bi * 12);
      tick();
    end
    drive(1'b0, 8'h0, 0);
    #2 RST = 1'b0;
    #1;
    check("rst_mid_hash0", if0.hashkey, 32'h0);
    check("rst_mid_hash1", if1.hashkey, 32'h0);
    check("rst_mid_complete", {31'b0, if0.complete}, 32'd0);
    tick();
    #2 RST = 1'b1;
    tick();
    check("post_rst_complete", {31'b0, if0.complete}, 32'd0);
    send(100, -1, 0, 1'b0);

    // Block-boundary lengths with random content and stalls
    foreach (edge_lens[i]) begin
      fill_rand();
      send(edge_lens[i], -1, 0, 1'b1);
    end

    // Fully random keys, sometimes back-to-back, sometimes spaced
    for (int m = 0; m < 24; m++) begin
      fill_rand();
      send(int'($urandom_range(0, 255)), -1, 0, 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hash.md
Name: hash

Overview:
- Streaming Jenkins lookup3 ("hashlittle") hash engine producing a 32-bit hash of a byte key of 0–255 bytes.
- The key arrives as 12-byte blocks (three 32-bit words) over consecutive enabled cycles.
- Sits beside a key-parsing front end that slices keys into k0/k1/k2 words. The result is used as a hash-table index.

Parameters:
INITVAL, 32'h0, lookup3 initval (seed) added to the initial state.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  reset, asynchronous, active-low.
enable  input  1  block strobe; k0/k1/k2 are consumed on each rising CLK edge where enable=1.
key_length  input  8  key length in bytes; sampled only on the first enabled cycle of a message.
k0  input  32  key bytes 12n+0..3, little-endian (byte 12n+0 in bits 7:0).
k1  input  32  key bytes 12n+4..7, little-endian.
k2  input  32  key bytes 12n+8..11, little-endian.
hashkey  output  32  last completed hash; holds until the next completion.
complete  output  1  one-cycle pulse, coincident with hashkey update.

Behaviour:
- Reset (RST=0, async): state IDLE, hashkey=0, complete=0, internal a/b/c/remaining cleared.
- States:
  - IDLE: waiting for the first block of a message.
  - ABSORB: message in progress, remaining>0.
- In either state, on a cycle with enable=0: no state change. complete=0. Stalls are allowed anywhere mid-message.
- IDLE with enable=1:
  - Initial value for this block: a=b=c=32'hdeadbeef+{24'b0,key_length}+INITVAL.
  - remaining=key_length.
  - The same cycle's k0..k2 form block 0, processed as below.
- key_length=0 (enable in IDLE): hashkey<=32'hdeadbeef+INITVAL, complete<=1, stay IDLE. k words ignored, no final mix.
- Block processing, starting from the current a/b/c:
  - remaining>12 (not last): a+=k0, b+=k1, c+=k2, then mix. remaining-=12, go to/stay in ABSORB.
  - 1<=remaining<=12 (last): zero every byte whose index within the block is >=remaining, add the masked words to a/b/c, then final.
  - After the last block: hashkey<=c, complete<=1 next edge, return to IDLE.
  - The last block includes exactly 12 bytes (no extra zero block when length is a multiple of 12).
- mix, all 32-bit modulo arithmetic, rot = rotate-left, steps in order:
  - a-=c; a^=rot(c,4); c+=b
  - b-=a; b^=rot(a,6); a+=c
  - c-=b; c^=rot(b,8); b+=a
  - a-=c; a^=rot(c,16); c+=b
  - b-=a; b^=rot(a,19); a+=c
  - c-=b; c^=rot(b,4); b+=a
- final, steps in order:
  - c^=b; c-=rot(b,14)
  - a^=c; a-=rot(c,11)
  - b^=a; b-=rot(a,25)
  - c^=b; c-=rot(b,16)
  - a^=c; a-=rot(c,4)
  - b^=a; b-=rot(a,14)
  - c^=b; c-=rot(b,24)
- Throughput and latency:
  - One block per enabled cycle; mix/final are combinational within the cycle.
  - Latency from the last-block edge to valid hashkey/complete: 1 edge (registered outputs).
  - An N-byte key needs ceil(N/12) enabled cycles (minimum 1). Max 22 cycles for 255 bytes.
- Back-to-back messages: enable in the cycle right after the last block starts a new message, sampling a new key_length. The complete pulse for the previous message still occurs.
- key_length changes outside the first cycle are ignored.
- Reset asserted mid-message aborts the message. No complete is generated.

Test Plan:
1. Reset, then enable=1 for one cycle with key_length=0, INITVAL=0 -> complete pulse, hashkey=32'hdeadbeef.
2. Key "Four score and seven years ago" (30 bytes, 3 blocks, 3 consecutive enable cycles), INITVAL=0 -> hashkey=32'h17770551 with a single complete pulse 1 edge after block 2.
3. Same key with INITVAL=1 -> hashkey=32'hcd628161.
4. Same 30-byte key with enable deasserted 3 cycles between blocks 1 and 2 -> identical hash 32'h17770551. No complete before the last block.
5. Keys "abc" (3), "abcdefghijkl" (12), "abcdefghijklmno" (15), 100/200/250-byte repeats of "abcdefghijklmnopqrst", sent back-to-back -> one complete per key, after 1/1/2/9/17/21 blocks. hashkey matches C lookup3 hashlittle(key,len,0) for each.
6. Assert RST mid-way through the 100-byte key -> hashkey=0 and complete=0 immediately. The next full key hashes correctly.
